// File: rtl/lzy_vm_pkg.sv
// lzy_vm_pkg: shared types and constants for the lzy_vm vending-machine controller.
//   state_e   : credit held (S0 = 0, S05 = 0.5, S10 = 1.0 yuan)
//   COIN_*    : coin-bus codes seen on D_in
package lzy_vm_pkg;

   typedef enum logic [1:0] {
      S0  = 2'd0,
      S05 = 2'd1,
      S10 = 2'd2
   } state_e;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_HALF = 2'b01;
   localparam logic [1:0] COIN_ONE  = 2'b10;
   localparam logic [1:0] COIN_BAD  = 2'b11;

   // True for the two codes that carry money.
   function automatic logic is_coin(input logic [1:0] code);
      return (code == COIN_HALF) || (code == COIN_ONE);
   endfunction

endpackage

// File: rtl/lzy_vm_coin_edge.sv
// lzy_vm_coin_edge: turns a level coin code into a one-shot coin event.
// A coin code passes through only on the first edge it is sampled, i.e. when the
// previous sample was COIN_NONE or COIN_BAD; otherwise COIN_NONE is emitted.
// The qualified code is combinational, so no latency is added.
// Ports:
//   Clk   in  clock
//   Reset in  asynchronous active-high reset (previous sample -> COIN_NONE)
//   D_in  in  raw coin code
//   coin  out qualified coin code
module lzy_vm_coin_edge
   import lzy_vm_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic [1:0] D_in,
   output logic [1:0] coin
);

   logic [1:0] prev_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) prev_q <= COIN_NONE;
      else       prev_q <= D_in;
   end

   always_comb begin
      coin = COIN_NONE;
      if (is_coin(D_in) && !is_coin(prev_q)) coin = D_in;
   end

endmodule

// File: rtl/lzy_vm.sv
// lzy_vm: vending-machine controller, one item at 1.5 yuan, 0.5/1 yuan coins.
// Emits a registered one-cycle dispense pulse and, on 2.0 yuan paid, a
// simultaneous one-cycle change pulse worth 0.5 yuan.
// Optional build macro LZY_VM_COIN_EDGE_EN: count a coin code only on its first
// sampled edge (held codes count once); otherwise every sampled coin code counts.
// Ports:
//   Clk   in  clock, rising edge
//   Reset in  asynchronous active-high reset
//   D_in  in  coin code: 00 none, 01 half, 10 one, 11 invalid (ignored)
//   D_out out dispense pulse
//   D_C   out change pulse, only ever together with D_out
module lzy_vm
   import lzy_vm_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic [1:0] D_in,
   output logic       D_out,
   output logic       D_C
);

   state_e     state_q, state_d;
   logic       dout_d, dc_d;
   logic [1:0] coin;

`ifdef LZY_VM_COIN_EDGE_EN
   lzy_vm_coin_edge u_coin_edge (
      .Clk   (Clk),
      .Reset (Reset),
      .D_in  (D_in),
      .coin  (coin)
   );
`else
   assign coin = D_in;
`endif

   always_comb begin
      state_d = state_q;
      dout_d  = 1'b0;
      dc_d    = 1'b0;
      case (state_q)
         S0: begin
            if (coin == COIN_HALF)     state_d = S05;
            else if (coin == COIN_ONE) state_d = S10;
         end
         S05: begin
            if (coin == COIN_HALF) begin
               state_d = S10;
            end else if (coin == COIN_ONE) begin
               state_d = S0;
               dout_d  = 1'b1;
            end
         end
         S10: begin
            if (coin == COIN_HALF) begin
               state_d = S0;
               dout_d  = 1'b1;
            end else if (coin == COIN_ONE) begin
               state_d = S0;
               dout_d  = 1'b1;
               dc_d    = 1'b1;
            end
         end
         // Unused encoding recovers to no credit.
         default: state_d = S0;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S0;
         D_out   <= 1'b0;
         D_C     <= 1'b0;
      end else begin
         state_q <= state_d;
         D_out   <= dout_d;
         D_C     <= dc_d;
      end
   end

endmodule

// File: tb/tb_lzy_vm.sv
// tb_lzy_vm: self-checking bench for lzy_vm. Directed vector table, hand-written
// reset sequences and randomized coins checked against a credit-counting model.
module tb_lzy_vm;

   logic       Clk;
   logic       Reset;
   logic [1:0] D_in;
   logic       D_out;
   logic       D_C;

   lzy_vm dut (
      .Clk   (Clk),
      .Reset (Reset),
      .D_in  (D_in),
      .D_out (D_out),
      .D_C   (D_C)
   );

   initial Clk = 1'b0;
   always #16 Clk = ~Clk;

`ifdef LZY_VM_COIN_EDGE_EN
   localparam bit EdgeMode = 1'b1;
`else
   localparam bit EdgeMode = 1'b0;
`endif

   int nvec  = 0;
   int nfail = 0;

   // Model: credit counted in half-yuan units, plus last sampled code.
   int         m_credit = 0;
   logic [1:0] m_prev   = 2'b00;

   task automatic model_reset();
      m_credit = 0;
      m_prev   = 2'b00;
   endtask

   task automatic model_coin(input logic [1:0] c, output bit mdo, output bit mdc);
      bit valid, counted;
      int total;
      mdo     = 1'b0;
      mdc     = 1'b0;
      valid   = (c == 2'b01) || (c == 2'b10);
      counted = valid && (!EdgeMode || !((m_prev == 2'b01) || (m_prev == 2'b10)));
      m_prev  = c;
      if (counted) begin
         total = m_credit + ((c == 2'b01) ? 1 : 2);
         if (total >= 3) begin
            mdo      = 1'b1;
            mdc      = (total == 4);
            m_credit = 0;
         end else begin
            m_credit = total;
         end
      end
   endtask

   task automatic check(input string name, input int idx, input bit edo, input bit edc);
      nvec++;
      if (D_out !== edo || D_C !== edc) begin
         nfail++;
         $display("FAIL %s[%0d]: got D_out=%b D_C=%b, want D_out=%b D_C=%b",
                  name, idx, D_out, D_C, edo, edc);
      end
   endtask

   // Called at a falling edge: drive c, let it be sampled, check at next falling edge.
   task automatic step(input string name, input int idx, input logic [1:0] c,
                       input bit use_tbl, input bit tdo, input bit tdc);
      bit mdo, mdc;
      model_coin(c, mdo, mdc);
      D_in = c;
      @(negedge Clk);
      if (use_tbl) check(name, idx, tdo, tdc);
      else         check(name, idx, mdo, mdc);
   endtask

   typedef struct packed {
      logic [1:0] coin;
      logic       edo;
      logic       edc;
   } vec_t;

   vec_t tbl [24];

   initial begin
      tbl = '{
         // exact payment 0.5 + 1
         '{2'b01, 1'b0, 1'b0}, '{2'b00, 1'b0, 1'b0}, '{2'b10, 1'b1, 1'b0}, '{2'b00, 1'b0, 1'b0},
         // overpayment 1 + 1
         '{2'b10, 1'b0, 1'b0}, '{2'b00, 1'b0, 1'b0}, '{2'b10, 1'b1, 1'b1}, '{2'b00, 1'b0, 1'b0},
         // invalid code ignored
         '{2'b01, 1'b0, 1'b0}, '{2'b00, 1'b0, 1'b0}, '{2'b11, 1'b0, 1'b0}, '{2'b00, 1'b0, 1'b0},
         '{2'b10, 1'b1, 1'b0}, '{2'b00, 1'b0, 1'b0},
         // three halves, then 1 + 1
         '{2'b01, 1'b0, 1'b0}, '{2'b00, 1'b0, 1'b0}, '{2'b01, 1'b0, 1'b0}, '{2'b00, 1'b0, 1'b0},
         '{2'b01, 1'b1, 1'b0}, '{2'b00, 1'b0, 1'b0}, '{2'b10, 1'b0, 1'b0}, '{2'b00, 1'b0, 1'b0},
         '{2'b10, 1'b1, 1'b1}, '{2'b00, 1'b0, 1'b0}
      };

      Reset = 1'b0;
      D_in  = 2'b00;

      // Power-on reset with the clock running; a rising edge falls inside it.
      #5  Reset = 1'b1;
      #15 check("por", 0, 1'b0, 1'b0);
      #5  Reset = 1'b0;
      model_reset();
      @(negedge Clk);
      check("por", 1, 1'b0, 1'b0);

      for (int i = 0; i < 24; i++) step("tbl", i, tbl[i].coin, 1'b1, tbl[i].edo, tbl[i].edc);

      // Mid-purchase reset: 1 yuan held, reset, then 0.5 must not dispense.
      step("midrst", 0, 2'b10, 1'b1, 1'b0, 1'b0);
      step("midrst", 1, 2'b00, 1'b1, 1'b0, 1'b0);
      #4 Reset = 1'b1;
      #4 Reset = 1'b0;
      model_reset();
      @(negedge Clk);
      step("midrst", 2, 2'b01, 1'b1, 1'b0, 1'b0);
      step("midrst", 3, 2'b00, 1'b1, 1'b0, 1'b0);
      step("midrst", 4, 2'b10, 1'b1, 1'b1, 1'b0);
      step("midrst", 5, 2'b00, 1'b1, 1'b0, 1'b0);

      // Reset during a dispense pulse clears outputs without waiting for a clock.
      step("asyrst", 0, 2'b10, 1'b1, 1'b0, 1'b0);
      step("asyrst", 1, 2'b00, 1'b1, 1'b0, 1'b0);
      step("asyrst", 2, 2'b10, 1'b1, 1'b1, 1'b1);
      D_in = 2'b00;
      #4 Reset = 1'b1;
      #1 check("asyrst", 3, 1'b0, 1'b0);
      #3 Reset = 1'b0;
      model_reset();
      @(negedge Clk);
      check("asyrst", 4, 1'b0, 1'b0);

      // Half coin held for three edges, then a gap and a one-yuan coin.
      for (int i = 0; i < 3; i++) step("hold", i, 2'b01, 1'b0, 1'b0, 1'b0);
      step("hold", 3, 2'b00, 1'b0, 1'b0, 1'b0);
      step("hold", 4, 2'b10, 1'b0, 1'b0, 1'b0);
      if (EdgeMode) begin
         // Counted once -> 0.5 + 1 completes the sale.
         check("hold_edge", 5, 1'b1, 1'b0);
      end
      step("hold", 6, 2'b00, 1'b0, 1'b0, 1'b0);
      step("hold", 7, 2'b00, 1'b0, 1'b0, 1'b0);
      model_reset();
      Reset = 1'b1;
      #2 Reset = 1'b0;
      @(negedge Clk);

      // Randomized coins, including invalid codes and back-to-back coins.
      for (int i = 0; i < 400; i++) begin
         logic [1:0] c;
         c = 2'($urandom_range(0, 3));
         step("rand", i, c, 1'b0, 1'b0, 1'b0);
      end
      step("rand_end", 0, 2'b00, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   // Backstop so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout: got no finish, want finish before 2 ms");
      $fatal(1);
   end

endmodule
